// File: rtl/dccm_dma_ctl.sv
// DMA-side initiator for the DCCM array: single-request read/write with SECDED
// generation, check/correction and read-modify-write for sub-word stores.
module dccm_dma_ctl #(
    parameter int unsigned DCCM_BITS   = 16,
    parameter int unsigned FDATA_WIDTH = 39
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic                   ecc_disable,
    input  logic                   dma_req_valid,
    output logic                   dma_req_ready,
    input  logic                   dma_req_write,
    input  logic [1:0]             dma_req_size,
    input  logic [DCCM_BITS-1:0]   dma_req_addr,
    input  logic [31:0]            dma_req_wdata,
    output logic                   dma_rsp_valid,
    input  logic                   dma_rsp_ready,
    output logic [31:0]            dma_rsp_rdata,
    output logic                   dma_rsp_err,
    output logic                   dma_rsp_sb,
    input  logic                   dccm_gnt,
    output logic                   dccm_rden,
    output logic [DCCM_BITS-1:0]   dccm_rd_addr_lo,
    output logic [DCCM_BITS-1:0]   dccm_rd_addr_hi,
    input  logic [FDATA_WIDTH-1:0] dccm_rd_data_lo,
    output logic                   dccm_wren,
    output logic [DCCM_BITS-1:0]   dccm_wr_addr,
    output logic [FDATA_WIDTH-1:0] dccm_wr_data
);

    localparam int unsigned DW       = 32;
    localparam int unsigned HW       = 6;
    localparam int unsigned CODE_LEN = 38;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_RDAT = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_e;

    // Hamming check bits: data occupies the non-power-of-two positions 1..38
    function automatic logic [HW-1:0] hamming(input logic [DW-1:0] d);
        logic [HW-1:0] h;
        logic [HW-1:0] pv;
        int unsigned   k;
        h = '0;
        k = 0;
        for (int unsigned pos = 1; pos <= CODE_LEN; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                pv = HW'(pos);
                for (int unsigned i = 0; i < HW; i++)
                    if (pv[i[2:0]]) h[i[2:0]] = h[i[2:0]] ^ d[k[4:0]];
                k++;
            end
        end
        return h;
    endfunction

    function automatic logic [HW:0] ecc_gen(input logic [DW-1:0] d);
        logic [HW-1:0] h;
        h = hamming(d);
        return {^{d, h}, h};
    endfunction

    function automatic logic [DW-1:0] flip_mask(input logic [HW-1:0] s);
        logic [DW-1:0] m;
        int unsigned   k;
        m = '0;
        k = 0;
        for (int unsigned pos = 1; pos <= CODE_LEN; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (HW'(pos) == s) m[k[4:0]] = 1'b1;
                k++;
            end
        end
        return m;
    endfunction

    state_e                 state_q, state_nx;
    logic                   write_q, write_nx;
    logic [1:0]             size_q, size_nx;
    logic [DCCM_BITS-1:0]   addr_q, addr_nx;
    logic [DW-1:0]          wdata_q, wdata_nx;
    logic                   corr_q, corr_nx;
    logic                   ready_q, ready_nx;
    logic                   rden_q, rden_nx;
    logic                   wren_q, wren_nx;
    logic [DCCM_BITS-1:0]   rd_addr_q, rd_addr_nx;
    logic [DCCM_BITS-1:0]   wr_addr_q, wr_addr_nx;
    logic [FDATA_WIDTH-1:0] wr_data_q, wr_data_nx;
    logic [DW-1:0]          wr_word_nx;
    logic                   rsp_valid_q, rsp_valid_nx;
    logic [DW-1:0]          rdata_q, rdata_nx;
    logic                   err_q, err_nx;
    logic                   sb_q, sb_nx;

    // Decode of the returned entry
    logic [DW-1:0] rd_raw;
    logic [HW:0]   rd_ecc;
    logic [HW-1:0] syn;
    logic          par;
    logic          sgl_err;
    logic          dbl_err;
    logic [DW-1:0] dec_data;

    assign rd_raw   = dccm_rd_data_lo[DW-1:0];
    assign rd_ecc   = dccm_rd_data_lo[DW+HW:DW];
    assign syn      = hamming(rd_raw) ^ rd_ecc[HW-1:0];
    assign par      = ^dccm_rd_data_lo;
    assign sgl_err  = !ecc_disable && par && (syn <= HW'(CODE_LEN));
    assign dbl_err  = !ecc_disable && ((!par && (syn != '0)) || (par && (syn > HW'(CODE_LEN))));
    assign dec_data = sgl_err ? (rd_raw ^ flip_mask(syn)) : rd_raw;

    logic          req_bad;
    logic [3:0]    be;
    logic [DW-1:0] lane_mask;
    logic [DW-1:0] merged;

    assign req_bad = (dma_req_size == 2'd3)
                   || ((dma_req_size == 2'd1) && dma_req_addr[0])
                   || ((dma_req_size == 2'd2) && (dma_req_addr[1:0] != 2'b00));

    always_comb begin
        be = 4'b1111;
        case (size_q)
            2'd0:    be = 4'b0001 << addr_q[1:0];
            2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    assign lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    assign merged    = (wdata_q & lane_mask) | (dec_data & ~lane_mask);

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q     <= S_IDLE;
            write_q     <= 1'b0;
            size_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            corr_q      <= 1'b0;
            ready_q     <= 1'b0;
            rden_q      <= 1'b0;
            wren_q      <= 1'b0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            sb_q        <= 1'b0;
        end else begin
            state_q     <= state_nx;
            write_q     <= write_nx;
            size_q      <= size_nx;
            addr_q      <= addr_nx;
            wdata_q     <= wdata_nx;
            corr_q      <= corr_nx;
            ready_q     <= ready_nx;
            rden_q      <= rden_nx;
            wren_q      <= wren_nx;
            rd_addr_q   <= rd_addr_nx;
            wr_addr_q   <= wr_addr_nx;
            wr_data_q   <= wr_data_nx;
            rsp_valid_q <= rsp_valid_nx;
            rdata_q     <= rdata_nx;
            err_q       <= err_nx;
            sb_q        <= sb_nx;
        end
    end

    // Next state; every output register is loaded from the state being entered
    always_comb begin
        state_nx   = state_q;
        write_nx   = write_q;
        size_nx    = size_q;
        addr_nx    = addr_q;
        wdata_nx   = wdata_q;
        corr_nx    = corr_q;
        wr_word_nx = wr_data_q[DW-1:0];
        rdata_nx   = '0;
        err_nx     = 1'b0;
        sb_nx      = 1'b0;

        case (state_q)
            S_IDLE: begin
                corr_nx = 1'b0;
                if (dma_req_valid) begin
                    write_nx = dma_req_write;
                    size_nx  = dma_req_size;
                    addr_nx  = dma_req_addr;
                    wdata_nx = dma_req_wdata;
                    if (req_bad) begin
                        state_nx = S_RESP;
                        err_nx   = 1'b1;
                    end else if (dma_req_write && (dma_req_size == 2'd2)) begin
                        state_nx   = S_WR;
                        wr_word_nx = dma_req_wdata;
                    end else begin
                        state_nx = S_RD;
                    end
                end
            end
            S_RD: begin
                if (dccm_gnt) state_nx = S_RDAT;
            end
            S_RDAT: begin
                if (!write_q) begin
                    state_nx = S_RESP;
                    rdata_nx = dbl_err ? '0 : dec_data;
                    err_nx   = dbl_err;
                    sb_nx    = sgl_err;
                end else if (dbl_err) begin
                    state_nx = S_RESP;
                    err_nx   = 1'b1;
                end else begin
                    state_nx   = S_WR;
                    wr_word_nx = merged;
                    corr_nx    = sgl_err;
                end
            end
            S_WR: begin
                if (dccm_gnt) begin
                    state_nx = S_RESP;
                    sb_nx    = corr_q;
                end
            end
            S_RESP: begin
                if (dma_rsp_ready) begin
                    state_nx = S_IDLE;
                end else begin
                    rdata_nx = rdata_q;
                    err_nx   = err_q;
                    sb_nx    = sb_q;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        ready_nx     = (state_nx == S_IDLE);
        rden_nx      = (state_nx == S_RD);
        wren_nx      = (state_nx == S_WR);
        rsp_valid_nx = (state_nx == S_RESP);
        rd_addr_nx   = rden_nx ? {addr_nx[DCCM_BITS-1:2], 2'b00} : '0;
        wr_addr_nx   = wren_nx ? {addr_nx[DCCM_BITS-1:2], 2'b00} : '0;
        wr_data_nx   = wren_nx ? FDATA_WIDTH'({ecc_gen(wr_word_nx), wr_word_nx}) : '0;
    end

    assign dma_req_ready   = ready_q;
    assign dccm_rden       = rden_q;
    assign dccm_rd_addr_lo = rd_addr_q;
    assign dccm_rd_addr_hi = rd_addr_q;
    assign dccm_wren       = wren_q;
    assign dccm_wr_addr    = wr_addr_q;
    assign dccm_wr_data    = wr_data_q;
    assign dma_rsp_valid   = rsp_valid_q;
    assign dma_rsp_rdata   = rdata_q;
    assign dma_rsp_err     = err_q;
    assign dma_rsp_sb      = sb_q;

endmodule

// File: tb/tb_dccm_dma_ctl.sv
// Directed bench for dccm_dma_ctl: behavioural DCCM array, response scoreboard,
// ECC checked by write/read round trips and injected bit flips.
module tb_dccm_dma_ctl;

    localparam int unsigned AB = 16;
    localparam int unsigned FW = 39;
    localparam int unsigned NWORDS = 1 << (AB - 2);

    logic          clk = 1'b0;
    logic          rst_l;
    logic          ecc_disable;
    logic          dma_req_valid;
    logic          dma_req_ready;
    logic          dma_req_write;
    logic [1:0]    dma_req_size;
    logic [AB-1:0] dma_req_addr;
    logic [31:0]   dma_req_wdata;
    logic          dma_rsp_valid;
    logic          dma_rsp_ready;
    logic [31:0]   dma_rsp_rdata;
    logic          dma_rsp_err;
    logic          dma_rsp_sb;
    logic          dccm_gnt;
    logic          dccm_rden;
    logic [AB-1:0] dccm_rd_addr_lo;
    logic [AB-1:0] dccm_rd_addr_hi;
    logic [FW-1:0] dccm_rd_data_lo;
    logic          dccm_wren;
    logic [AB-1:0] dccm_wr_addr;
    logic [FW-1:0] dccm_wr_data;

    dccm_dma_ctl #(.DCCM_BITS(AB), .FDATA_WIDTH(FW)) dut (
        .clk             (clk),
        .rst_l           (rst_l),
        .ecc_disable     (ecc_disable),
        .dma_req_valid   (dma_req_valid),
        .dma_req_ready   (dma_req_ready),
        .dma_req_write   (dma_req_write),
        .dma_req_size    (dma_req_size),
        .dma_req_addr    (dma_req_addr),
        .dma_req_wdata   (dma_req_wdata),
        .dma_rsp_valid   (dma_rsp_valid),
        .dma_rsp_ready   (dma_rsp_ready),
        .dma_rsp_rdata   (dma_rsp_rdata),
        .dma_rsp_err     (dma_rsp_err),
        .dma_rsp_sb      (dma_rsp_sb),
        .dccm_gnt        (dccm_gnt),
        .dccm_rden       (dccm_rden),
        .dccm_rd_addr_lo (dccm_rd_addr_lo),
        .dccm_rd_addr_hi (dccm_rd_addr_hi),
        .dccm_rd_data_lo (dccm_rd_data_lo),
        .dccm_wren       (dccm_wren),
        .dccm_wr_addr    (dccm_wr_addr),
        .dccm_wr_data    (dccm_wr_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        sb;
        int          lat;
    } exp_t;

    exp_t        sbq[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [FW-1:0] mem [NWORDS];
    logic        rden_seen, wren_seen, both_seen;

    // DCCM array model: one-cycle read latency, writes on granted strobe
    always @(posedge clk) begin
        if (dccm_rden && dccm_gnt) dccm_rd_data_lo <= mem[dccm_rd_addr_lo[AB-1:2]];
        if (dccm_wren && dccm_gnt) mem[dccm_wr_addr[AB-1:2]] = dccm_wr_data;
    end

    always @(negedge clk) begin
        if (dccm_rden) rden_seen = 1'b1;
        if (dccm_wren) wren_seen = 1'b1;
        if (dccm_rden && dccm_wren) both_seen = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_rsp(input logic [31:0] rdata, input logic err, input logic sb, input int lat);
        exp_t e;
        e.rdata = rdata; e.err = err; e.sb = sb; e.lat = lat;
        sbq.push_back(e);
    endtask

    // Present a request at a negedge; returns at the first negedge after acceptance
    task automatic send(input logic wr, input logic [1:0] size, input logic [AB-1:0] addr,
                        input logic [31:0] wdata);
        int n;
        rden_seen = 1'b0;
        wren_seen = 1'b0;
        dma_req_valid = 1'b1;
        dma_req_write = wr;
        dma_req_size  = size;
        dma_req_addr  = addr;
        dma_req_wdata = wdata;
        n = 0;
        while (!dma_req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("req_accept_timeout", 64'(dma_req_ready), 64'd1);
        @(negedge clk);
        dma_req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        exp_t        e;
        int          lat;
        logic [31:0] first;
        lat = 1;
        while (!dma_rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_valid"}, 64'(dma_rsp_valid), 64'd1);
        e = sbq.pop_front();
        if (e.lat != 0) check({tag, "_latency"}, 64'(lat), 64'(e.lat));
        check({tag, "_rdata"}, 64'(dma_rsp_rdata), 64'(e.rdata));
        check({tag, "_err"}, 64'(dma_rsp_err), 64'(e.err));
        check({tag, "_sb"}, 64'(dma_rsp_sb), 64'(e.sb));
        first = dma_rsp_rdata;
        repeat (2) @(negedge clk);
        check({tag, "_hold_valid"}, 64'(dma_rsp_valid), 64'd1);
        check({tag, "_hold_rdata"}, 64'(dma_rsp_rdata), 64'(first));
        dma_rsp_ready = 1'b1;
        @(negedge clk);
        dma_rsp_ready = 1'b0;
        check({tag, "_release"}, 64'({dma_rsp_valid, dma_req_ready}), 64'b01);
    endtask

    initial begin
        for (int i = 0; i < int'(NWORDS); i++) mem[i] = '0;
        dccm_rd_data_lo = '0;
        rst_l = 1'b0; ecc_disable = 1'b0; dma_req_valid = 1'b0; dma_req_write = 1'b0;
        dma_req_size = 2'd0; dma_req_addr = '0; dma_req_wdata = '0;
        dma_rsp_ready = 1'b0; dccm_gnt = 1'b1;
        rden_seen = 1'b0; wren_seen = 1'b0; both_seen = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_ready", 64'(dma_req_ready), 64'd0);
        check("reset_outputs", 64'({dccm_rden, dccm_wren, dma_rsp_valid, dma_rsp_err, dma_rsp_sb}), 64'd0);
        check("reset_wr_data", 64'(dccm_wr_data), 64'd0);
        rst_l = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(dma_req_ready), 64'd1);

        // word write
        expect_rsp(32'h0, 1'b0, 1'b0, 2);
        send(1'b1, 2'd2, 16'h0100, 32'h1234ABCD);
        check("ww_wren", 64'(dccm_wren), 64'd1);
        check("ww_addr", 64'(dccm_wr_addr), 64'h0100);
        check("ww_data", 64'(dccm_wr_data[31:0]), 64'h1234ABCD);
        wait_rsp("ww");
        check("ww_mem", 64'(mem[16'h0100 >> 2][31:0]), 64'h1234ABCD);

        // read back: clean ECC, 3-cycle latency
        expect_rsp(32'h1234ABCD, 1'b0, 1'b0, 3);
        send(1'b0, 2'd2, 16'h0100, 32'h0);
        check("rd_rden", 64'(dccm_rden), 64'd1);
        check("rd_addr_hi", 64'(dccm_rd_addr_hi), 64'h0100);
        wait_rsp("rd");

        // byte RMW into lane 3
        expect_rsp(32'h0, 1'b0, 1'b0, 0);
        send(1'b1, 2'd0, 16'h0103, 32'hEE00_0000);
        wait_rsp("bw");
        check("bw_mem", 64'(mem[16'h0100 >> 2][31:0]), 64'hEE34ABCD);
        expect_rsp(32'hEE34ABCD, 1'b0, 1'b0, 3);
        send(1'b0, 2'd2, 16'h0100, 32'h0);
        wait_rsp("bw_rd");

        // single then double data error
        mem[16'h0100 >> 2][5] = ~mem[16'h0100 >> 2][5];
        expect_rsp(32'hEE34ABCD, 1'b0, 1'b1, 3);
        send(1'b0, 2'd2, 16'h0100, 32'h0);
        wait_rsp("sbe");
        mem[16'h0100 >> 2][12] = ~mem[16'h0100 >> 2][12];
        expect_rsp(32'h0, 1'b1, 1'b0, 3);
        send(1'b0, 2'd2, 16'h0100, 32'h0);
        wait_rsp("dbe");
        ecc_disable = 1'b1;
        expect_rsp(32'hEE34ABCD ^ 32'h0000_1020, 1'b0, 1'b0, 3);
        send(1'b0, 2'd2, 16'h0100, 32'h0);
        wait_rsp("eccdis");
        ecc_disable = 1'b0;

        // alignment / illegal-size errors: no DCCM traffic
        expect_rsp(32'h0, 1'b1, 1'b0, 1);
        send(1'b1, 2'd1, 16'h0101, 32'h0000_5500);
        wait_rsp("half_mis");
        check("half_mis_no_strobe", 64'({rden_seen, wren_seen}), 64'd0);
        expect_rsp(32'h0, 1'b1, 1'b0, 1);
        send(1'b0, 2'd3, 16'h0100, 32'h0);
        wait_rsp("size3");
        expect_rsp(32'h0, 1'b1, 1'b0, 1);
        send(1'b0, 2'd2, 16'h0102, 32'h0);
        wait_rsp("word_mis");
        check("mis_no_strobe", 64'({rden_seen, wren_seen}), 64'd0);

        // halfword and byte merges
        expect_rsp(32'h0, 1'b0, 1'b0, 2);
        send(1'b1, 2'd2, 16'h0204, 32'h55667788);
        wait_rsp("ww2");
        expect_rsp(32'h0, 1'b0, 1'b0, 0);
        send(1'b1, 2'd1, 16'h0206, 32'hBEEF_0000);
        wait_rsp("hw");
        expect_rsp(32'h0, 1'b0, 1'b0, 0);
        send(1'b1, 2'd0, 16'h0205, 32'h0000_AA00);
        wait_rsp("bw1");
        expect_rsp(32'hBEEFAA88, 1'b0, 1'b0, 3);
        send(1'b0, 2'd1, 16'h0206, 32'h0);
        wait_rsp("hw_rd");

        // RMW over a corrected word, then over an uncorrectable one
        mem[16'h0204 >> 2][30] = ~mem[16'h0204 >> 2][30];
        expect_rsp(32'h0, 1'b0, 1'b1, 0);
        send(1'b1, 2'd0, 16'h0204, 32'h0000_0011);
        wait_rsp("rmw_sbe");
        expect_rsp(32'hBEEFAA11, 1'b0, 1'b0, 3);
        send(1'b0, 2'd2, 16'h0204, 32'h0);
        wait_rsp("rmw_sbe_rd");
        mem[16'h0204 >> 2][1:0] = ~mem[16'h0204 >> 2][1:0];
        expect_rsp(32'h0, 1'b1, 1'b0, 0);
        send(1'b1, 2'd0, 16'h0207, 32'h2200_0000);
        wait_rsp("rmw_dbe");
        check("rmw_dbe_no_wren", 64'(wren_seen), 64'd0);
        check("rmw_dbe_mem", 64'(mem[16'h0204 >> 2][31:0]), 64'hBEEFAA12);

        // grant withheld for 5 cycles in RD
        dccm_gnt = 1'b0;
        expect_rsp(32'h0, 1'b0, 1'b0, 0);
        send(1'b0, 2'd2, 16'h0300, 32'h0);
        for (int i = 0; i < 5; i++) begin
            check("gnt0_rden", 64'({dccm_rden, dccm_rd_addr_lo, dma_req_ready}), 64'({1'b1, 16'h0300, 1'b0}));
            @(negedge clk);
        end
        dccm_gnt = 1'b1;
        wait_rsp("gnt0");

        // error confined to the overall parity bit
        mem[16'h0300 >> 2][38] = ~mem[16'h0300 >> 2][38];
        expect_rsp(32'h0, 1'b0, 1'b1, 3);
        send(1'b0, 2'd2, 16'h0300, 32'h0);
        wait_rsp("par_bit");

        // reset while waiting for grant in WR
        dccm_gnt = 1'b0;
        send(1'b1, 2'd2, 16'h0400, 32'hCAFEF00D);
        check("rst_wr_wren", 64'(dccm_wren), 64'd1);
        @(negedge clk);
        rst_l = 1'b0;
        @(negedge clk);
        check("rst_mid_outputs", 64'({dccm_wren, dma_rsp_valid, dma_req_ready, dccm_wr_addr}), 64'd0);
        @(negedge clk);
        rst_l = 1'b1;
        dccm_gnt = 1'b1;
        @(negedge clk);
        check("rst_mid_release", 64'({dma_req_ready, dma_rsp_valid}), 64'b10);
        repeat (3) @(negedge clk);
        check("rst_mid_no_rsp", 64'(dma_rsp_valid), 64'd0);
        check("rst_mid_mem", 64'(mem[16'h0400 >> 2]), 64'd0);

        check("strobes_exclusive", 64'(both_seen), 64'd0);
        check("scoreboard_empty", 64'(sbq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
